// File: rtl/polar_pkg.sv
// Shared types and mask helpers for the polar frame-building path.
// Masks are passed right-aligned: u[i] of an n-bit mask sits at bit n-1-i.
package polar_pkg;

  localparam int POLAR_MAX_N = 1024;
  localparam logic [15:0] POLAR_MASK_16_8 = 16'hFE80;

  typedef enum logic {FILL, HOLD} fi_state_t;

  function automatic int count_info(input logic [POLAR_MAX_N-1:0] mask, input int n);
    logic [POLAR_MAX_N-1:0] m;
    int c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      m = mask >> (n - 1 - i);
      if (!m[0]) c++;
    end
    return c;
  endfunction

  // u-index of the k-th information (unfrozen) position, ascending; -1 if absent
  function automatic int info_pos(input logic [POLAR_MAX_N-1:0] mask, input int n, input int k);
    logic [POLAR_MAX_N-1:0] m;
    int c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      m = mask >> (n - 1 - i);
      if (!m[0]) begin
        if (c == k) return i;
        c++;
      end
    end
    return -1;
  endfunction

endpackage

// File: rtl/polar_frozen_insert.sv
// Purpose: serial info bits -> N-bit u vector with frozen positions held at 0.
// Latency: out_valid one cycle after the K-th accepted bit; in_ready one cycle after output accept.
// Backpressure: in_ready low while a frame is held; the frame stays stable until out_ready.
module polar_frozen_insert
  import polar_pkg::*;
#(
  parameter int              N           = 16,
  parameter int              K           = 8,
  parameter logic [0:N-1]    FROZEN_MASK = POLAR_MASK_16_8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_bit,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [0:N-1] output_bits,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         frame_err
);

  localparam int KW = $clog2(K + 1);
  localparam int IW = $clog2(N);
  localparam logic [POLAR_MAX_N-1:0] MASK_EXT = POLAR_MAX_N'(FROZEN_MASK);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  if (count_info(MASK_EXT, N) != K) begin : g_bad_mask
    $fatal(1, "polar_frozen_insert: FROZEN_MASK zero count differs from K");
  end

  fi_state_t     state_q;
  logic [KW-1:0] k_q;
  logic [0:N-1]  u_q;
  logic [0:N-1]  u_d;
  logic          err_q;

  // Write-decode: slot k maps to the k-th information position; frozen bits are never targeted.
  always_comb begin
    u_d = u_q;
    for (int j = 0; j < K; j++) begin
      if (k_q == KW'(j)) u_d[IW'(info_pos(MASK_EXT, N, j))] = in_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      k_q     <= '0;
      u_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (in_valid) begin
            u_q <= u_d;
            if (k_q == K_LAST) begin
              k_q     <= '0;
              state_q <= HOLD;
              err_q   <= !in_last;
            end else if (in_last) begin
              k_q   <= '0;
              err_q <= 1'b1;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) state_q <= FILL;
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready    = (state_q == FILL);
  assign out_valid   = (state_q == HOLD);
  assign output_bits = u_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_polar_frozen_insert.sv
// Scoreboard bench for polar_frozen_insert with the default 16/8 mask.
module tb_polar_frozen_insert;

  localparam int N = 16;
  localparam int K = 8;
  localparam logic [0:N-1] MASK = 16'hFE80;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_bit = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [0:N-1] output_bits;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         frame_err;

  int checks = 0;
  int failures = 0;

  polar_frozen_insert #(.N(N), .K(K), .FROZEN_MASK(MASK)) dut (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .output_bits(output_bits), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames are lists of bits placed at the mask's zero positions.
  int           info_idx[$];
  logic         cur_bits[$];
  logic [0:N-1] exp_q[$];
  bit           m_hold = 0;
  bit           m_err = 0;
  int           cyc = 0;
  int           deliver_cyc[$];

  function automatic logic [0:N-1] build_frame(input int unused);
    logic [0:N-1] v;
    v = '0;
    for (int j = 0; j < K; j++) v[info_idx[j]] = cur_bits[j];
    return v;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) if (!MASK[i]) info_idx.push_back(i);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cur_bits.delete();
        exp_q.delete();
        m_hold = 0;
        m_err = 0;
      end else begin
        cyc++;
        m_err = 0;
        if (m_hold) begin
          if (out_ready) begin
            m_hold = 0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            deliver_cyc.push_back(cyc);
          end
        end else if (in_valid) begin
          cur_bits.push_back(in_bit);
          if (cur_bits.size() == K) begin
            exp_q.push_back(build_frame(0));
            m_hold = 1;
            m_err = !in_last;
            cur_bits.delete();
          end else if (in_last) begin
            cur_bits.delete();
            m_err = 1;
          end
        end
      end
    end
  end

  // Monitor: compares every observable output once per cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bits", output_bits, 0);
        chk("rst_frame_err", frame_err, 0);
      end else begin
        chk("in_ready", in_ready, !m_hold);
        chk("out_valid", out_valid, m_hold);
        chk("frame_err", frame_err, m_err);
        if (m_hold) begin
          if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
          else chk("output_bits", output_bits, exp_q[0]);
        end
      end
    end
  end

  task automatic push_bit(input logic b, input logic last);
    logic rdy;
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_bit = b;
    in_last = last;
    do begin
      rdy = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 64);
    if (!rdy) chk("push_timeout", 1, 0);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic deliver();
    logic v;
    int guard;
    guard = 0;
    out_ready = 1'b1;
    do begin
      v = out_valid;
      @(posedge clk); #1;
      guard++;
    end while (!v && guard < 64);
    if (!v) chk("deliver_timeout", 1, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    int n0;
    logic rdy;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;

    // all ones, in_last on the 8th bit
    for (int i = 0; i < K; i++) push_bit(1'b1, i == K - 1);
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_vec", output_bits, 16'h017F);
    @(posedge clk); #1;
    deliver();

    // alternating bits, held frame ignores in_valid while out_ready is low
    for (int i = 0; i < K; i++) push_bit(logic'((i % 2) == 0), i == K - 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      in_bit = 1'($urandom);
      @(negedge clk);
      chk("t2_vec", output_bits, 16'h012A);
      chk("t2_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    deliver();

    // early in_last aborts the frame
    push_bit(1'b1, 1'b0);
    push_bit(1'b0, 1'b0);
    push_bit(1'b1, 1'b1);
    @(negedge clk);
    chk("t3_err", frame_err, 1);
    chk("t3_valid", out_valid, 0);
    @(posedge clk); #1;
    for (int i = 0; i < K; i++) push_bit(1'b1, i == K - 1);
    @(negedge clk);
    chk("t3_vec", output_bits, 16'h017F);
    @(posedge clk); #1;
    deliver();

    // missing in_last: delivered with an error pulse
    for (int i = 0; i < K; i++) push_bit(1'b1, 1'b0);
    @(negedge clk);
    chk("t4_err", frame_err, 1);
    chk("t4_valid", out_valid, 1);
    chk("t4_vec", output_bits, 16'h017F);
    @(posedge clk); #1;
    deliver();

    // reset mid-frame
    for (int i = 0; i < 5; i++) push_bit(1'($urandom), 1'b0);
    rst_n = 1'b0;
    #2;
    chk("t5_ready", in_ready, 1);
    chk("t5_valid", out_valid, 0);
    chk("t5_bits", output_bits, 0);
    chk("t5_err", frame_err, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < K; i++) push_bit(1'($urandom), i == K - 1);
    deliver();

    // back-to-back streaming: one frame every K+1 cycles
    n0 = deliver_cyc.size();
    cnt = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 6 * (K + 1); c++) begin
      in_bit = 1'($urandom);
      in_last = (cnt == K - 1);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) cnt = (cnt + 1) % K;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (deliver_cyc.size() - n0 < 3) chk("t6_frames", deliver_cyc.size() - n0, 3);
    else chk("t6_period", deliver_cyc[$] - deliver_cyc[$-1], K + 1);
    out_ready = 1'b0;
    @(posedge clk); #1;
    if (out_valid) deliver();

    // randomized traffic with occasional framing errors
    cnt = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_bit = 1'($urandom);
      in_last = ($urandom_range(0, 15) == 0) ? 1'($urandom) : (cnt == K - 1);
      out_ready = 1'($urandom);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy && in_valid) cnt = (in_last || cnt == K - 1) ? 0 : cnt + 1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
